// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for a 5-stage RISC-V core.
// Turns load-use, branch and memory-handshake conditions into per-stage
// write enables and bubble inserts, waits out slow data-memory accesses
// with a timeout into a sticky error state, and keeps saturating
// stall and flush counters.
module pipeline_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 nop,
  input  logic                 branchTaken,
  input  logic                 memReq,
  input  logic                 memReady,
  input  logic                 instrReady,
  output logic                 pcWrite,
  output logic                 IF_ID_write,
  output logic                 IF_ID_flush,
  output logic                 ID_EX_write,
  output logic                 ID_EX_flush,
  output logic                 EX_MEM_write,
  output logic                 MEM_WB_flush,
  output logic                 memError,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stallCycles,
  output logic [CNT_WIDTH-1:0] flushCount
);

  typedef enum logic [1:0] {
    S_RUN         = 2'b00,
    S_LOAD_BUBBLE = 2'b01,
    S_MEM_WAIT    = 2'b10,
    S_ERROR       = 2'b11
  } state_t;

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            cur_state;
  state_t            nxt_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              freeze;
  logic              advance;
  logic              nop_ok;
  logic              branch_flush;

  assign state    = cur_state;
  assign memError = (cur_state == S_ERROR);

  // State and wait-counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state <= S_RUN;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
    end
  end

  // Next-state decode and stage controls; freeze/advance flags pick the
  // shared priority chain so MEM_WAIT reuses the RUN rules on completion.
  always_comb begin
    pcWrite      = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_write  = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_flush = 1'b0;
    nxt_state    = cur_state;
    wait_nxt     = wait_cnt;
    freeze       = 1'b0;
    advance      = 1'b0;
    nop_ok       = 1'b0;
    branch_flush = 1'b0;

    if (!reset) begin
      pcWrite      = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      MEM_WB_flush = 1'b1;
    end else begin
      case (cur_state)
        S_ERROR: begin
          pcWrite      = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_write  = 1'b0;
          EX_MEM_write = 1'b0;
        end
        S_MEM_WAIT: begin
          if (!memReady) begin
            freeze    = 1'b1;
            wait_nxt  = wait_cnt + 1'b1;
            nxt_state = (wait_cnt == WAIT_LAST) ? S_ERROR : S_MEM_WAIT;
          end else begin
            advance  = 1'b1;
            nop_ok   = 1'b1;
            wait_nxt = '0;
          end
        end
        default: begin
          if (memReq && !memReady) begin
            freeze    = 1'b1;
            nxt_state = S_MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end else begin
            advance  = 1'b1;
            nop_ok   = (cur_state == S_RUN);
            wait_nxt = '0;
          end
        end
      endcase

      if (freeze) begin
        pcWrite      = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_write  = 1'b0;
        EX_MEM_write = 1'b0;
        MEM_WB_flush = 1'b1;
      end else if (advance) begin
        nxt_state = S_RUN;
        if (branchTaken) begin
          IF_ID_flush  = 1'b1;
          ID_EX_flush  = 1'b1;
          branch_flush = 1'b1;
        end else if (nop && nop_ok) begin
          pcWrite     = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
          nxt_state   = S_LOAD_BUBBLE;
        end else if (!instrReady) begin
          pcWrite     = 1'b0;
          IF_ID_flush = 1'b1;
        end
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (!pcWrite && (cur_state != S_ERROR) && (stallCycles != '1))
        stallCycles <= stallCycles + 1'b1;
      if (branch_flush && (flushCount != '1))
        flushCount <= flushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a driver applies one vector
// per cycle and queues its hand-computed expectation; a monitor pops and
// compares on the following falling edge.
module tb_pipeline_stall_controller;

  logic       clock = 1'b0;
  logic       reset, nop, branchTaken, memReq, memReady, instrReady;
  logic       pcWrite, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush;
  logic       EX_MEM_write, MEM_WB_flush, memError;
  logic [1:0] state;
  logic [3:0] stallCycles, flushCount;

  int checks   = 0;
  int failures = 0;

  // Output bundle order: pcWrite IF_ID_write IF_ID_flush ID_EX_write
  //                      ID_EX_flush EX_MEM_write MEM_WB_flush memError
  localparam logic [7:0] O_DEF = 8'b1101_0100;
  localparam logic [7:0] O_RST = 8'b0010_1010;
  localparam logic [7:0] O_FRZ = 8'b0000_0010;
  localparam logic [7:0] O_BR  = 8'b1111_1100;
  localparam logic [7:0] O_NOP = 8'b0001_1100;
  localparam logic [7:0] O_IRD = 8'b0111_0100;
  localparam logic [7:0] O_ERR = 8'b0000_0001;

  typedef struct {
    int         idx;
    logic [7:0] outs;
    logic [1:0] st;
    int         stall;
    int         fl;
  } exp_t;

  exp_t sb[$];
  int   vec_idx = 0;

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .nop(nop), .branchTaken(branchTaken),
    .memReq(memReq), .memReady(memReady), .instrReady(instrReady),
    .pcWrite(pcWrite), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_write(ID_EX_write), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_write(EX_MEM_write), .MEM_WB_flush(MEM_WB_flush),
    .memError(memError), .state(state), .stallCycles(stallCycles),
    .flushCount(flushCount)
  );

  // Free-running clock
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  // Monitor: compare the expectation queued for this cycle
  always @(negedge clock) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("outs", e.idx, int'({pcWrite, IF_ID_write, IF_ID_flush, ID_EX_write,
                               ID_EX_flush, EX_MEM_write, MEM_WB_flush, memError}),
          int'(e.outs));
      chk("state", e.idx, int'(state), int'(e.st));
      chk("stallCycles", e.idx, int'(stallCycles), e.stall);
      chk("flushCount", e.idx, int'(flushCount), e.fl);
    end
  end

  task automatic step(input logic r, input logic n, input logic b, input logic mq,
                      input logic mr, input logic ir, input logic [7:0] o,
                      input logic [1:0] s, input int sc, input int fc);
    exp_t e;
    @(posedge clock);
    #1;
    reset = r; nop = n; branchTaken = b; memReq = mq; memReady = mr; instrReady = ir;
    e.idx = vec_idx; e.outs = o; e.st = s; e.stall = sc; e.fl = fc;
    sb.push_back(e);
    vec_idx++;
  endtask

  // Driver: directed vectors (rst nop br memReq memReady instrReady | outs state stall flush)
  initial begin
    reset = 1'b0; nop = 1'b0; branchTaken = 1'b0;
    memReq = 1'b0; memReady = 1'b0; instrReady = 1'b1;
    // reset held three cycles, then idle
    repeat (3) step(0,0,0,0,0,1, O_RST, 2'b00, 0, 0);
    step(1,0,0,0,0,1, O_DEF, 2'b00, 0, 0);
    // load-use: one bubble only, nop ignored in LOAD_BUBBLE
    step(1,1,0,0,0,1, O_NOP, 2'b00, 0, 0);
    step(1,1,0,0,0,1, O_DEF, 2'b01, 1, 0);
    step(1,0,0,0,0,1, O_DEF, 2'b00, 1, 0);
    // three freeze cycles then completion
    step(1,0,0,1,0,1, O_FRZ, 2'b00, 1, 0);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 2, 0);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 3, 0);
    step(1,0,0,1,1,1, O_DEF, 2'b10, 4, 0);
    step(1,0,0,0,0,1, O_DEF, 2'b00, 4, 0);
    // branch beats nop
    step(1,1,1,0,0,1, O_BR,  2'b00, 4, 0);
    step(1,0,0,0,0,1, O_DEF, 2'b00, 4, 1);
    // freeze beats branch; flush fires on the memReady cycle
    step(1,0,1,1,0,1, O_FRZ, 2'b00, 4, 1);
    step(1,0,1,1,1,1, O_BR,  2'b10, 5, 1);
    step(1,0,0,0,0,1, O_DEF, 2'b00, 5, 2);
    // fetch not ready
    step(1,0,0,0,0,0, O_IRD, 2'b00, 5, 2);
    // load-use allowed on the MEM_WAIT completion cycle
    step(1,0,0,1,0,1, O_FRZ, 2'b00, 6, 2);
    step(1,1,0,1,1,1, O_NOP, 2'b10, 7, 2);
    step(1,1,0,0,0,1, O_DEF, 2'b01, 8, 2);
    // stall counter saturates at 15
    for (int i = 0; i < 9; i++)
      step(1,0,0,0,0,0, O_IRD, 2'b00, (8 + i > 15) ? 15 : 8 + i, 2);
    step(1,0,0,0,0,1, O_DEF, 2'b00, 15, 2);
    // timeout after MEM_TIMEOUT freeze cycles; ERROR ignores inputs
    step(1,0,0,1,0,1, O_FRZ, 2'b00, 15, 2);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 15, 2);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 15, 2);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 15, 2);
    step(1,0,1,1,1,1, O_ERR, 2'b11, 15, 2);
    step(1,1,0,1,0,1, O_ERR, 2'b11, 15, 2);
    step(1,0,0,0,0,0, O_ERR, 2'b11, 15, 2);
    // reset clears error and counters asynchronously
    step(0,0,0,0,0,1, O_RST, 2'b00, 0, 0);
    step(1,0,0,0,0,1, O_DEF, 2'b00, 0, 0);
    // reset mid-MEM_WAIT, then a fresh wait must not inherit the old count
    step(1,0,0,1,0,1, O_FRZ, 2'b00, 0, 0);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 1, 0);
    step(0,0,0,1,0,1, O_RST, 2'b00, 0, 0);
    step(1,0,0,0,0,1, O_DEF, 2'b00, 0, 0);
    step(1,0,0,1,0,1, O_FRZ, 2'b00, 0, 0);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 1, 0);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 2, 0);
    step(1,0,0,1,1,1, O_DEF, 2'b10, 3, 0);
    step(1,0,0,0,0,1, O_DEF, 2'b00, 3, 0);
    // ERROR cycles are not counted as stalls
    step(1,0,0,1,0,1, O_FRZ, 2'b00, 3, 0);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 4, 0);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 5, 0);
    step(1,0,0,1,0,1, O_FRZ, 2'b10, 6, 0);
    step(1,0,0,1,0,0, O_ERR, 2'b11, 7, 0);
    step(1,0,0,0,0,0, O_ERR, 2'b11, 7, 0);

    repeat (3) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
